instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/y86_pkg.sv | 20 ++
 rtl/imem_window.sv | 57 +++++
 rtl/instr_mem_loader.sv | 137 +++++++++++++
 tb/tb_instr_mem_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the instruction-memory loader: loader state
// encoding, fetch-window geometry and the fill bytes used for nop/halt.
package y86_pkg;

  // Loader state encoding (plain constants over a 2-bit vector).
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_CHECK = 2'd2;
  localparam state_t ST_RUN   = 2'd3;

  // Fetch window: 10 bytes, the longest y86 instruction.
  localparam int WIN_BYTES = 10;
  localparam int WIN_W     = WIN_BYTES * 8;

  // Fill bytes: nop stream while no program runs, halt past the program end.
  localparam logic [7:0] NOP_BYTE  = 8'h10;
  localparam logic [7:0] HALT_BYTE = 8'h00;

endpackage

// File: rtl/imem_window.sv
// Instruction byte storage with a single synchronous write port and a
// combinational 10-byte fetch window. Bytes at or past loaded_len read as
// halt; a window that would run past the end of memory raises imem_error.
module imem_window
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  parameter int LEN_W     = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(MEM_BYTES)-1:0] wr_addr,
  input  logic [7:0]               wr_data,
  input  logic                     run,
  input  logic [LEN_W-1:0]         loaded_len,
  input  logic [63:0]              pc,
  output logic [WIN_W-1:0]         instr,
  output logic                     imem_error
);

  localparam int          AW      = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - WIN_BYTES);

  logic [7:0]  mem [MEM_BYTES];
  logic [7:0]  win [WIN_BYTES];
  logic [63:0] len_ext;

  assign len_ext = 64'(loaded_len);

  // Byte storage: written only by the loader, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Per-byte fetch with halt masking beyond the resident program.
  for (genvar g = 0; g < WIN_BYTES; g++) begin : g_byte
    logic [63:0] addr;
    assign addr   = pc + 64'(g);
    assign win[g] = (addr < len_ext) ? mem[addr[AW-1:0]] : HALT_BYTE;
  end

  // Window assembly: nop stream when not running, zeros on out-of-range PC.
  always_comb begin
    instr      = '0;
    imem_error = 1'b0;
    if (!run) begin
      instr = {WIN_BYTES{NOP_BYTE}};
    end else if (pc > LAST_PC) begin
      imem_error = 1'b1;
    end else begin
      for (int i = 0; i < WIN_BYTES; i++) begin
        instr[(WIN_BYTES-1-i)*8 +: 8] = win[i];
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Program loader for the y86 instruction memory.
// A load_start with a legal length opens a byte stream (ld_valid/ld_ready);
// once load_len bytes are in, the program runs and the processor fetches a
// 10-byte window at PC. Optional macro IMEM_CHECKSUM_EN adds a trailing
// 8-bit checksum byte that must match the mod-256 sum of the payload.
//
// Handshake: a byte transfers on a rising edge where ld_valid and ld_ready
// are both high; ld_ready depends only on state, never on ld_valid.
module instr_mem_loader
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             ld_valid,
  input  logic [7:0]       ld_data,
  output logic             ld_ready,
  output logic             load_done,
  output logic             load_err,
  output logic             run,
  output logic [LEN_W-1:0] loaded_len,
  input  logic [63:0]      PC,
  output logic [79:0]      instr,
  output logic             imem_error,
  output logic [1:0]       dbg_state
);

  localparam int               AW      = $clog2(MEM_BYTES);
  localparam logic [LEN_W:0]   MAX_LEN = (LEN_W+1)'(MEM_BYTES);

  state_t           state;
  logic [LEN_W-1:0] wptr;
  logic [LEN_W-1:0] tgt_len;
  logic             len_ok;
  logic             accept;
  logic             last_byte;
  logic             wr_en;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign len_ok    = (load_len != '0) && ({1'b0, load_len} <= MAX_LEN);
  assign ld_ready  = (state == ST_LOAD) || (state == ST_CHECK);
  assign accept    = ld_valid && ld_ready;
  assign last_byte = (wptr == tgt_len - 1'b1);
  assign wr_en     = accept && (state == ST_LOAD);
  assign dbg_state = state;

  // Loader FSM: start/validate a load, collect bytes, optionally verify.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wptr       <= '0;
      tgt_len    <= '0;
      loaded_len <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      run        <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      load_done <= 1'b0;
      case (state)
        ST_IDLE, ST_RUN: begin
          if (load_start) begin
            run <= 1'b0;
            if (len_ok) begin
              load_err   <= 1'b0;
              wptr       <= '0;
              loaded_len <= '0;
              tgt_len    <= load_len;
`ifdef IMEM_CHECKSUM_EN
              csum       <= '0;
`endif
              state      <= ST_LOAD;
            end else begin
              load_err <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            wptr       <= wptr + 1'b1;
            loaded_len <= wptr + 1'b1;
`ifdef IMEM_CHECKSUM_EN
            csum       <= csum + ld_data;
            if (last_byte) state <= ST_CHECK;
`else
            if (last_byte) begin
              state     <= ST_RUN;
              run       <= 1'b1;
              load_done <= 1'b1;
            end
`endif
          end
        end
`ifdef IMEM_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            if (ld_data == csum) begin
              state     <= ST_RUN;
              run       <= 1'b1;
              load_done <= 1'b1;
            end else begin
              load_err <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  imem_window #(
    .MEM_BYTES (MEM_BYTES),
    .LEN_W     (LEN_W)
  ) u_window (
    .clk        (clk),
    .wr_en      (wr_en),
    .wr_addr    (wptr[AW-1:0]),
    .wr_data    (ld_data),
    .run        (run),
    .loaded_len (loaded_len),
    .pc         (PC),
    .instr      (instr),
    .imem_error (imem_error)
  );

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed loads, a spec-level model of the
// resident program (byte array + length + run flag) checked every cycle,
// and literal expectations at the interesting points.
module tb_instr_mem_loader;
  import y86_pkg::*;

  localparam int MEM_BYTES = 4096;
  localparam int LEN_W     = 16;

  logic             clk;
  logic             rst_n;
  logic             load_start;
  logic [LEN_W-1:0] load_len;
  logic             ld_valid;
  logic [7:0]       ld_data;
  logic             ld_ready;
  logic             load_done;
  logic             load_err;
  logic             run;
  logic [LEN_W-1:0] loaded_len;
  logic [63:0]      PC;
  logic [79:0]      instr;
  logic             imem_error;
  logic [1:0]       dbg_state;

  instr_mem_loader #(
    .MEM_BYTES (MEM_BYTES),
    .LEN_W     (LEN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_len   (load_len),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .load_done  (load_done),
    .load_err   (load_err),
    .run        (run),
    .loaded_len (loaded_len),
    .PC         (PC),
    .instr      (instr),
    .imem_error (imem_error),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model / scoreboard ----------------
  logic [7:0] model_mem [MEM_BYTES];
  logic [7:0] exp_q [$];
  int         model_len;
  bit         exp_run, exp_ready, exp_done, exp_err;
  bit         chk_en;
  int         checks, errors;
  int         wr_cnt;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0] csum;
`endif

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {imem_error, instr} from the resident program and PC.
  function automatic logic [80:0] model_window(input logic [63:0] pc);
    logic [79:0] w;
    logic [63:0] a;
    if (!exp_run) return {1'b0, {10{8'h10}}};
    if (pc > 64'(MEM_BYTES - 10)) return {1'b1, 80'h0};
    w = '0;
    for (int i = 0; i < 10; i++) begin
      a = pc + 64'(i);
      if (a < 64'(model_len)) w[79-8*i -: 8] = model_mem[int'(a)];
    end
    return {1'b0, w};
  endfunction

  // Per-cycle compare of every observable output against the model.
  always @(negedge clk) begin
    logic [80:0] ew;
    if (chk_en) begin
      ew = model_window(PC);
      check("run",        80'(run),        80'(exp_run));
      check("ld_ready",   80'(ld_ready),   80'(exp_ready));
      check("load_done",  80'(load_done),  80'(exp_done));
      check("load_err",   80'(load_err),   80'(exp_err));
      check("loaded_len", 80'(loaded_len), 80'(model_len[LEN_W-1:0]));
      check("instr",      instr,           ew[79:0]);
      check("imem_error", 80'(imem_error), 80'(ew[80]));
    end
  end

  // Count accepted bytes.
  always @(posedge clk) begin
    if (rst_n && ld_valid && ld_ready) wr_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    exp_done = 1'b0;
  endtask

  task automatic start_load(input int len);
    load_start = 1'b1;
    load_len   = LEN_W'(len);
    step();
    load_start = 1'b0;
    exp_run    = 1'b0;
    if (len == 0 || len > MEM_BYTES) begin
      exp_err   = 1'b1;
      exp_ready = 1'b0;
    end else begin
      exp_err   = 1'b0;
      exp_ready = 1'b1;
      model_len = 0;
`ifdef IMEM_CHECKSUM_EN
      csum = 8'h00;
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    ld_valid = 1'b1;
    ld_data  = b;
    step();
    ld_valid = 1'b0;
    model_mem[model_len] = b;
    model_len++;
`ifdef IMEM_CHECKSUM_EN
    csum = csum + b;
`else
    if (last) begin
      exp_run   = 1'b1;
      exp_done  = 1'b1;
      exp_ready = 1'b0;
    end
`endif
  endtask

`ifdef IMEM_CHECKSUM_EN
  task automatic send_cs(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_data  = b;
    step();
    ld_valid  = 1'b0;
    exp_ready = 1'b0;
    if (b == csum) begin
      exp_run  = 1'b1;
      exp_done = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
  endtask
`endif

  task automatic run_load(input int len, input bit gap);
    start_load(len);
    for (int i = 0; i < len; i++) begin
      send_byte(exp_q.pop_front(), i == len - 1);
      if (gap) step();
    end
`ifdef IMEM_CHECKSUM_EN
    send_cs(csum);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; load_start = 1'b0; load_len = '0;
    ld_valid = 1'b0; ld_data = '0; PC = '0;
    checks = 0; errors = 0; wr_cnt = 0; model_len = 0;
    exp_run = 0; exp_ready = 0; exp_done = 0; exp_err = 0;
    chk_en = 1'b1;

    // Reset state
    step(); step();
    check("rst_run",   80'(run), 80'(0));
    check("rst_instr", instr, 80'h10101010101010101010);
    check("rst_state", 80'(dbg_state), 80'(ST_IDLE));
    rst_n = 1'b1;
    step();

    // Four-byte program, fetch at PC=0 and PC=1
    exp_q.push_back(8'h10); exp_q.push_back(8'h60);
    exp_q.push_back(8'h23); exp_q.push_back(8'h00);
    run_load(4, 1'b0);
    check("p4_done",  80'(load_done), 80'(1));
    check("p4_instr", instr, 80'h10602300000000000000);
    check("p4_err",   80'(imem_error), 80'(0));
    PC = 64'd1; #1;
    check("p4_pc1", instr, 80'h60230000000000000000);
    step();

    // Range boundaries, full-width compare
    PC = 64'(MEM_BYTES - 9); #1;
    check("pc_m9_err",   80'(imem_error), 80'(1));
    check("pc_m9_instr", instr, 80'h0);
    step();
    PC = 64'(MEM_BYTES - 10); #1;
    check("pc_m10_err", 80'(imem_error), 80'(0));
    step();
    PC = 64'hFFFF_FFFF_FFFF_FFFA; #1;
    check("pc_wrap_err", 80'(imem_error), 80'(1));
    step();
    PC = '0;

    // Zero length from RUN, then oversize
    start_load(0);
    step(); step();
    check("len0_err", 80'(load_err), 80'(1));
    check("len0_run", 80'(run), 80'(0));
    check("len0_rdy", 80'(ld_ready), 80'(0));
    start_load(MEM_BYTES + 1);
    step();
    check("big_err", 80'(load_err), 80'(1));

    // Eight bytes with ld_valid toggled every other cycle
    wr_cnt = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h30 + 8'(i * 5)));
    run_load(8, 1'b1);
    step();
`ifdef IMEM_CHECKSUM_EN
    check("gap_writes", 80'(wr_cnt), 80'(9));
`else
    check("gap_writes", 80'(wr_cnt), 80'(8));
`endif
    check("gap_len", 80'(loaded_len), 80'(8));
    PC = 64'd3; step(); step();
    PC = '0;

    // load_start ignored mid-load
    start_load(3);
    send_byte(8'hA1, 1'b0);
    load_start = 1'b1; load_len = '0;
    step();
    load_start = 1'b0;
    check("ign_err", 80'(load_err), 80'(0));
    check("ign_rdy", 80'(ld_ready), 80'(1));
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b1);
`ifdef IMEM_CHECKSUM_EN
    send_cs(csum);
`endif
    check("ign_run", 80'(run), 80'(1));
    step();

    // Full memory load, window at the top boundary
    for (int i = 0; i < MEM_BYTES; i++) exp_q.push_back(8'((i * 13 + 5) & 255));
    run_load(MEM_BYTES, 1'b0);
    PC = 64'(MEM_BYTES - 10); #1;
    check("full_last", 80'(instr[7:0]), 80'(8'hF8));
    step();
    PC = 64'(MEM_BYTES - 11); step();
    PC = 64'd0; step();

    // Reset after 3 of 6 bytes
    start_load(6);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    rst_n = 1'b0;
    exp_run = 0; exp_ready = 0; exp_done = 0; exp_err = 0; model_len = 0;
    #1;
    check("abort_run",   80'(run), 80'(0));
    check("abort_len",   80'(loaded_len), 80'(0));
    check("abort_instr", instr, 80'h10101010101010101010);
    check("abort_state", 80'(dbg_state), 80'(ST_IDLE));
    step(); step();
    rst_n = 1'b1;
    step();

`ifdef IMEM_CHECKSUM_EN
    // Checksum good and bad
    start_load(2);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    send_cs(8'h03);
    check("cs_good_run", 80'(run), 80'(1));
    step();
    start_load(2);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    send_cs(8'h04);
    check("cs_bad_err", 80'(load_err), 80'(1));
    check("cs_bad_run", 80'(run), 80'(0));
    step();
`endif

    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
